counter_up_down_mod: RTL and testbench

Parameterised up/down counter with programmable modulo limit, wrap or saturate mode, parallel load, enable and clock-enable prescaler. Registered terminal-count pulse and sticky wrap flag. General-purpose timing/event counter for timers, PWM period generation and event tallying. Successor to the fixed free-running up/down counter.

---
 rtl/counter_pkg.sv | 10 +
 rtl/counter_up_down_mod_if.sv | 31 +++
 rtl/counter_prescaler.sv | 30 +++
 rtl/counter_up_down_mod.sv | 98 +++++++++
 tb/tb_counter_up_down_mod.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode/direction encodings for counter and timer blocks
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/counter_up_down_mod_if.sv
// rtl/counter_up_down_mod_if.sv - control and status bundle for counter_up_down_mod
interface counter_up_down_mod_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);

  logic                  en;
  logic                  up_down;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      limit;
  logic                  sat_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  clr_wrap;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  wrapped;
  logic                  at_max;
  logic                  at_min;

  modport master (
    output en, up_down, load, load_value, limit, sat_mode, prescale, clr_wrap,
    input  count, tc, wrapped, at_max, at_min
  );

  modport slave (
    input  en, up_down, load, load_value, limit, sat_mode, prescale, clr_wrap,
    output count, tc, wrapped, at_max, at_min
  );

endinterface

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - clock-enable divider: tick every prescale+1 enabled cycles
module counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  // >= rather than == so a prescale lowered below the current phase ticks at once
  assign tick = en && (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_up_down_mod.sv
// rtl/counter_up_down_mod.sv - up/down modulo counter with wrap/saturate, load and prescaler
module counter_up_down_mod
  import counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_up_down_mod_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_q;
  logic             tc_nxt;
  logic             wrapped_q;
  logic             wrap_evt;
  logic             tick;
  logic             step;
  logic             wrap_mode;
  logic             going_down;

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .clear    (bus.load),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  assign step       = tick && !bus.load;
  assign wrap_mode  = (bus.sat_mode == MODE_WRAP);
  assign going_down = (bus.up_down == DIR_DOWN);

  // Boundary compares come before +/-1, so the arithmetic never leaves 0..limit.
  always_comb begin
    count_nxt = count_q;
    tc_nxt    = 1'b0;
    wrap_evt  = 1'b0;
    if (bus.load) begin
      count_nxt = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
    end else if (step) begin
      if (!going_down) begin
        if (count_q < bus.limit) begin
          count_nxt = count_q + WIDTH'(1);
        end else begin
          tc_nxt = 1'b1;
          if (wrap_mode) begin
            count_nxt = '0;
            wrap_evt  = 1'b1;
          end else begin
            count_nxt = bus.limit;
          end
        end
      end else begin
        if (count_q > bus.limit) begin
          count_nxt = bus.limit;
        end else if (count_q != '0) begin
          count_nxt = count_q - WIDTH'(1);
        end else begin
          tc_nxt = 1'b1;
          if (wrap_mode) begin
            count_nxt = bus.limit;
            wrap_evt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
      // a wrap in the same cycle as a clear must remain visible
      if (wrap_evt) begin
        wrapped_q <= 1'b1;
      end else if (bus.clr_wrap) begin
        wrapped_q <= 1'b0;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;
  assign bus.at_max  = (count_q >= bus.limit);
  assign bus.at_min  = (count_q == '0);

endmodule

// File: tb/tb_counter_up_down_mod.sv
// tb/tb_counter_up_down_mod.sv - directed and randomized checks against a behavioural model
module tb_counter_up_down_mod;

  localparam int W = 8;
  localparam int P = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_up_down_mod_if #(.WIDTH(W), .PRESCALE_W(P)) bus ();

  counter_up_down_mod #(.WIDTH(W), .PRESCALE_W(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  int m_count;
  int m_phase;
  int m_tc;
  int m_wrapped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, using the input values currently applied.
  task automatic model_edge();
    int lim;
    int fire;
    int wrap_evt;
    lim      = int'(bus.limit);
    wrap_evt = 0;
    if (reset) begin
      m_count = 0; m_phase = 0; m_tc = 0; m_wrapped = 0;
      return;
    end
    fire = (bus.en && m_phase >= int'(bus.prescale)) ? 1 : 0;
    if (bus.load)            m_phase = 0;
    else if (bus.en)         m_phase = fire ? 0 : m_phase + 1;
    m_tc = 0;
    if (bus.load) begin
      m_count = (int'(bus.load_value) > lim) ? lim : int'(bus.load_value);
    end else if (fire) begin
      if (bus.up_down) begin
        if (m_count < lim) m_count = m_count + 1;
        else begin
          m_tc = 1;
          if (bus.sat_mode) m_count = lim;
          else begin m_count = 0; wrap_evt = 1; end
        end
      end else begin
        if (m_count > lim)      m_count = lim;
        else if (m_count > 0)   m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (!bus.sat_mode) begin m_count = lim; wrap_evt = 1; end
        end
      end
    end
    if (wrap_evt)          m_wrapped = 1;
    else if (bus.clr_wrap) m_wrapped = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("count",   32'(bus.count),   32'(m_count));
    check("tc",      32'(bus.tc),      32'(m_tc));
    check("wrapped", 32'(bus.wrapped), 32'(m_wrapped));
    check("at_max",  32'(bus.at_max),  32'((m_count >= int'(bus.limit)) ? 1 : 0));
    check("at_min",  32'(bus.at_min),  32'((m_count == 0) ? 1 : 0));
  endtask

  initial begin
    m_count = 0; m_phase = 0; m_tc = 0; m_wrapped = 0;
    reset = 1'b1;
    bus.en = 1'b0; bus.up_down = 1'b1; bus.load = 1'b0; bus.load_value = '0;
    bus.limit = 8'd5; bus.sat_mode = 1'b0; bus.prescale = '0; bus.clr_wrap = 1'b0;

    // reset state
    cyc(); cyc();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_flags", {29'd0, bus.tc, bus.wrapped, bus.at_min}, 32'd1);

    // wrap mode, count up through limit 5
    reset = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check("up_seq", 32'(bus.count), 32'(i % 6));
    end
    check("wrap_tc", 32'(bus.tc), 32'd1);
    check("wrap_flag", 32'(bus.wrapped), 32'd1);

    // saturate down from 2, sticky flag cleared alongside the load
    bus.sat_mode = 1'b1; bus.up_down = 1'b0; bus.load = 1'b1; bus.load_value = 8'd2; bus.clr_wrap = 1'b1;
    cyc();
    bus.load = 1'b0; bus.clr_wrap = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("sat_hold", 32'(bus.count), 32'd0);
    check("sat_tc", 32'(bus.tc), 32'd1);
    check("sat_noflag", 32'(bus.wrapped), 32'd0);

    // prescale=2 with an enable gap mid-phase
    bus.sat_mode = 1'b0; bus.up_down = 1'b1; bus.limit = 8'd255; bus.prescale = 8'd2;
    bus.load = 1'b1; bus.load_value = 8'd0;
    cyc();
    bus.load = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    check("pre_count", 32'(bus.count), 32'd2);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("pre_frozen", 32'(bus.count), 32'd2);
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    check("pre_resume", 32'(bus.count), 32'd5);

    // load above limit clamps, then wraps on the next up step
    bus.prescale = 8'd0; bus.limit = 8'd100; bus.load = 1'b1; bus.load_value = 8'd200;
    cyc();
    check("clamp", 32'(bus.count), 32'd100);
    check("clamp_max", 32'(bus.at_max), 32'd1);
    bus.load = 1'b0;
    cyc();
    check("clamp_wrap", {bus.count, 23'd0, bus.tc}, {8'd0, 23'd0, 1'b1});

    // limit lowered under the count
    bus.limit = 8'd255; bus.load = 1'b1; bus.load_value = 8'd50;
    cyc();
    bus.load = 1'b0; bus.limit = 8'd10; bus.up_down = 1'b0;
    cyc();
    check("lower_down", {bus.count, 23'd0, bus.tc}, {8'd10, 23'd0, 1'b0});
    bus.up_down = 1'b1;
    cyc();
    check("lower_up", {bus.count, 23'd0, bus.tc}, {8'd0, 23'd0, 1'b1});

    // reset beats load and step; wrap beats clr_wrap
    reset = 1'b1; bus.load = 1'b1; bus.load_value = 8'd7;
    cyc();
    check("rst_prio", {bus.count, 21'd0, bus.tc, bus.wrapped, 1'b0}, 32'd0);
    reset = 1'b0; bus.load = 1'b0; bus.limit = 8'd0; bus.clr_wrap = 1'b1;
    cyc();
    check("set_wins", 32'(bus.wrapped), 32'd1);
    bus.clr_wrap = 1'b0;

    // randomized traffic
    bus.limit = 8'd6;
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.load       = ($urandom_range(0, 9) == 0);
      bus.en         = ($urandom_range(0, 3) != 0);
      bus.up_down    = 1'($urandom_range(0, 1));
      bus.clr_wrap   = ($urandom_range(0, 7) == 0);
      bus.load_value = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 19) == 0) bus.limit    = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0)  bus.sat_mode = ~bus.sat_mode;
      if ($urandom_range(0, 15) == 0) bus.prescale = 8'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
